// File: rtl/latch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// latch_ctrl_pkg
//   Shared types and constants for the latch write sequencer.
//   - state_e : write-sequence phases (IDLE, SETUP, ENABLE, HOLD)
//   - CNT_W   : width of the enable-duration counter (covers EN_CYCLES 1..15)
// -----------------------------------------------------------------------------
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int CNT_W = 4;

endpackage : latch_ctrl_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. The search for a winner starts at the rotating
//   pointer; the pointer moves to (winner + 1) mod NREQ only when the caller
//   commits the grant via 'advance'. After reset requester 0 has top priority.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   [NREQ]  request vector
//   advance  in   commit the current winner and rotate the pointer
//   grant    out  [NREQ]  one-hot winner (combinational, zero if no request)
//   winner   out  [IW]    index of the winner
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   winner
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // Rotating priority search: visit ptr, ptr+1, ... wrapping at NREQ.
  always_comb begin
    int  idx;
    logic found;
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch instead of a mux.
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = IW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter

// File: rtl/latch_wr_sequencer.sv
// -----------------------------------------------------------------------------
// latch_wr_sequencer
//   Shared write controller for a bank of DEPTH level-sensitive D latches.
//   Arbitrates NREQ requesters round-robin and sequences each write as
//   grant -> SETUP -> ENABLE (EN_CYCLES) -> HOLD so the D bus is stable for a
//   full cycle before and after every enable pulse.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   [NREQ]        per-requester write request (level)
//   req_addr  in   [NREQ*AW]     packed target entry, slice i = requester i
//   req_data  in   [NREQ*WIDTH]  packed write data,   slice i = requester i
//   gnt       out  [NREQ]        one-cycle one-hot grant pulse
//   lat_d     out  [WIDTH]       shared latch D bus
//   lat_en    out  [DEPTH]       one-hot per-entry latch enable
//   busy      out  high while a write sequence (SETUP..HOLD) is in progress
//   addr_err  out  one-cycle pulse when the granted address is >= DEPTH
// -----------------------------------------------------------------------------
module latch_wr_sequencer
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int EN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      lat_d,
  output logic [DEPTH-1:0]      lat_en,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] EN_LOAD = CNT_W'(EN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [AW-1:0]     addr_q, addr_sel;
  logic [WIDTH-1:0]  data_q, data_sel;
  logic [WIDTH-1:0]  lat_d_q;
  logic [DEPTH-1:0]  lat_en_q, lat_en_d, en_dec;
  logic              busy_q;
  logic              addr_err_q, addr_err_d;
  logic              addr_ok;
  logic              grant_fire;

  logic [NREQ-1:0]   arb_grant;
  logic [IW-1:0]     arb_winner;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (grant_fire),
    .grant   (arb_grant),
    .winner  (arb_winner)
  );

  // Route the winner's address/data slice to the capture registers.
  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i == int'(arb_winner)) begin
        addr_sel = req_addr[i*AW +: AW];
        data_sel = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Enable decode of the captured address; out-of-range addresses decode to 0.
  always_comb begin
    addr_ok = (int'(addr_q) < DEPTH);
    en_dec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      en_dec[i] = (int'(addr_q) == i);
    end
  end

  // Next-state and next-output logic. Requests are arbitrated in a quiet IDLE
  // cycle (no grant pending) or in HOLD, so the registered grant lands in the
  // IDLE cycle right after HOLD and back-to-back writes lose no cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_en_d   = '0;
    addr_err_d = 1'b0;
    grant_fire = (|req) &&
                 (((state_q == ST_IDLE) && (gnt_q == '0)) || (state_q == ST_HOLD));
    gnt_d      = grant_fire ? arb_grant : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|gnt_q) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d    = ST_ENABLE;
        cnt_d      = EN_LOAD;
        addr_err_d = !addr_ok;   // visible on the first ENABLE cycle only
      end
      ST_ENABLE: begin
        if (cnt_q == '0) state_d = ST_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_ENABLE) && addr_ok) lat_en_d = en_dec;
  end

  // NOTE: every register, including the address/data capture registers, is
  // reset; the asynchronous reset is what pulls lat_en low mid-write without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      lat_d_q    <= '0;
      lat_en_q   <= '0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      lat_en_q   <= lat_en_d;
      busy_q     <= (state_d != ST_IDLE);
      addr_err_q <= addr_err_d;
      if (grant_fire) begin
        addr_q <= addr_sel;
        data_q <= data_sel;
      end
      // The D bus moves only when leaving the grant cycle for SETUP, i.e. a
      // full cycle after the previous HOLD and a full cycle before ENABLE.
      if ((state_q == ST_IDLE) && (|gnt_q)) begin
        lat_d_q <= data_q;
      end
    end
  end

  assign gnt      = gnt_q;
  assign lat_d    = lat_d_q;
  assign lat_en   = lat_en_q;
  assign busy     = busy_q;
  assign addr_err = addr_err_q;

endmodule : latch_wr_sequencer

// File: tb/tb_latch_wr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_latch_wr_sequencer
//   Directed bench for latch_wr_sequencer. dut_a uses the default geometry
//   (4 requesters, DEPTH 4, EN_CYCLES 1); dut_b uses DEPTH 3, EN_CYCLES 3 for
//   the long-enable and out-of-range address cases. Outputs are sampled 1 ns
//   after each rising edge, where inputs are also driven.
// -----------------------------------------------------------------------------
module tb_latch_wr_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0]  req_a,  req_b;
  logic [7:0]  req_addr_a, req_addr_b;
  logic [31:0] req_data_a, req_data_b;
  logic [3:0]  gnt_a,  gnt_b;
  logic [7:0]  lat_d_a, lat_d_b;
  logic [3:0]  lat_en_a;
  logic [2:0]  lat_en_b;
  logic        busy_a, busy_b, addr_err_a, addr_err_b;

  int tests = 0;
  int fails = 0;

  logic [7:0] model [4];   // contents of dut_a's latch array
  logic [3:0] prev_gnt;
  int         busy_cnt, err_cnt, en_cnt;

  always #5 clk = ~clk;

  latch_wr_sequencer #(
    .NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2), .EN_CYCLES(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .req_addr(req_addr_a),
    .req_data(req_data_a), .gnt(gnt_a), .lat_d(lat_d_a), .lat_en(lat_en_a),
    .busy(busy_a), .addr_err(addr_err_a)
  );

  latch_wr_sequencer #(
    .NREQ(4), .WIDTH(8), .DEPTH(3), .AW(2), .EN_CYCLES(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_addr(req_addr_b),
    .req_data(req_data_b), .gnt(gnt_b), .lat_d(lat_d_b), .lat_en(lat_en_b),
    .busy(busy_b), .addr_err(addr_err_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, update the latch model and check enable one-hotness.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (lat_en_a[i]) model[i] = lat_d_a;
    end
    check("lat_en_a_onehot0", 64'($countones(lat_en_a) <= 1), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_a = '0; req_addr_a = '0; req_data_a = '0;
    req_b = '0; req_addr_b = '0; req_data_b = '0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    prev_gnt = '0;

    // ---- Reset / idle ---------------------------------------------------
    step();
    check("rst_a_outputs", 64'({gnt_a, lat_d_a, lat_en_a, busy_a, addr_err_a}), 64'(0));
    check("rst_b_outputs", 64'({gnt_b, lat_d_b, lat_en_b, busy_b, addr_err_b}), 64'(0));
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_a", 64'({gnt_a, lat_d_a, lat_en_a, busy_a, addr_err_a}), 64'(0));
      check("idle_b", 64'({gnt_b, lat_d_b, lat_en_b, busy_b, addr_err_b}), 64'(0));
    end

    // ---- All four requesting: grants 0,1,2,3, four cycles apart ----------
    for (int i = 0; i < 4; i++) begin
      req_addr_a[i*2 +: 2] = 2'(i);
      req_data_a[i*8 +: 8] = 8'(17 * (i + 1));   // 0x11, 0x22, 0x33, 0x44
    end
    req_a = 4'b1111;
    prev_gnt = '0;
    for (int c = 0; c < 16; c++) begin
      step();
      req_a    = req_a & ~prev_gnt;   // requester drops req the cycle after gnt
      prev_gnt = gnt_a;
      check("all4_gnt", 64'(gnt_a), (c % 4 == 0) ? 64'(1 << (c / 4)) : 64'(0));
    end
    step();
    check("all4_idle_busy", 64'(busy_a), 64'(0));
    check("all4_latch0", 64'(model[0]), 64'(8'h11));
    check("all4_latch1", 64'(model[1]), 64'(8'h22));
    check("all4_latch2", 64'(model[2]), 64'(8'h33));
    check("all4_latch3", 64'(model[3]), 64'(8'h44));

    // ---- Fairness: req0 continuous, req3 once -> grants 0, 3, 0 ----------
    req_addr_a[0 +: 2] = 2'd0;  req_data_a[0 +: 8]  = 8'h60;
    req_addr_a[6 +: 2] = 2'd3;  req_data_a[24 +: 8] = 8'h63;
    req_a = 4'b1001;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 5) req_a[3] = 1'b0;
      if (c == 9) req_a[0] = 1'b0;
      check("fair_gnt", 64'(gnt_a),
            (c == 0 || c == 8) ? 64'(4'b0001) : (c == 4) ? 64'(4'b1000) : 64'(0));
    end
    step();
    check("fair_latch3", 64'(model[3]), 64'(8'h63));
    check("fair_latch0", 64'(model[0]), 64'(8'h60));

    // ---- Single write: req[2], addr 3, data 0xA5 -------------------------
    req_addr_a[4 +: 2] = 2'd3;
    req_data_a[16 +: 8] = 8'hA5;
    req_a = 4'b0100;
    step();   // t: grant cycle, req still high
    check("single_t_gnt", 64'(gnt_a), 64'(4'b0100));
    check("single_t_busy", 64'(busy_a), 64'(0));
    check("single_t_lat_d_old", 64'(lat_d_a), 64'(8'h60));
    check("single_t_lat_en", 64'(lat_en_a), 64'(0));
    step();   // t+1: SETUP
    req_a = '0;
    check("single_setup_gnt", 64'(gnt_a), 64'(0));
    check("single_setup_lat_d", 64'(lat_d_a), 64'(8'hA5));
    check("single_setup_lat_en", 64'(lat_en_a), 64'(0));
    check("single_setup_busy", 64'(busy_a), 64'(1));
    step();   // t+2: ENABLE
    check("single_en_lat_en", 64'(lat_en_a), 64'(4'b1000));
    check("single_en_lat_d", 64'(lat_d_a), 64'(8'hA5));
    step();   // t+3: HOLD
    check("single_hold_lat_en", 64'(lat_en_a), 64'(0));
    check("single_hold_lat_d", 64'(lat_d_a), 64'(8'hA5));
    check("single_hold_busy", 64'(busy_a), 64'(1));
    step();   // t+4: idle again
    check("single_done_busy", 64'(busy_a), 64'(0));
    check("single_done_gnt", 64'(gnt_a), 64'(0));
    check("single_latch3", 64'(model[3]), 64'(8'hA5));

    // ---- dut_b: EN_CYCLES=3, out-of-range addr 3 with DEPTH=3 ------------
    req_addr_b[0 +: 2] = 2'd3;
    req_data_b[0 +: 8] = 8'h77;
    req_b = 4'b0001;
    step();
    check("oor_gnt", 64'(gnt_b), 64'(4'b0001));
    check("oor_gnt_busy", 64'(busy_b), 64'(0));
    busy_cnt = 0; err_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) req_b = '0;
      busy_cnt += int'(busy_b);
      err_cnt  += int'(addr_err_b);
      check("oor_lat_en", 64'(lat_en_b), 64'(0));
      check("oor_addr_err", 64'(addr_err_b), (c == 2) ? 64'(1) : 64'(0));
      check("oor_busy", 64'(busy_b), (c <= 5) ? 64'(1) : 64'(0));
    end
    check("oor_busy_len", 64'(busy_cnt), 64'(5));
    check("oor_err_pulses", 64'(err_cnt), 64'(1));

    // dut_b valid write, addr 2: enable held three cycles
    req_addr_b[2 +: 2] = 2'd2;
    req_data_b[8 +: 8] = 8'h3C;
    req_b = 4'b0010;
    step();
    check("long_gnt", 64'(gnt_b), 64'(4'b0010));
    en_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) req_b = '0;
      en_cnt += int'(lat_en_b == 3'b100);
      check("long_lat_en", 64'(lat_en_b), (c >= 2 && c <= 4) ? 64'(3'b100) : 64'(0));
      check("long_lat_d", 64'(lat_d_b), 64'(8'h3C));
      check("long_addr_err", 64'(addr_err_b), 64'(0));
    end
    check("long_en_len", 64'(en_cnt), 64'(3));

    // ---- Reset mid-ENABLE --------------------------------------------------
    req_addr_a[2 +: 2] = 2'd1;
    req_data_a[8 +: 8] = 8'h5A;
    req_a = 4'b0010;
    step();
    check("midrst_gnt", 64'(gnt_a), 64'(4'b0010));
    step();
    req_a = '0;
    step();
    check("midrst_lat_en_high", 64'(lat_en_a), 64'(4'b0010));
    #2;
    rst_n = 1'b0;
    #1;   // still before the next clock edge
    check("midrst_lat_en_async", 64'(lat_en_a), 64'(0));
    check("midrst_busy_async", 64'(busy_a), 64'(0));
    check("midrst_lat_d_async", 64'(lat_d_a), 64'(0));
    step();
    rst_n = 1'b1;
    req_addr_a[0 +: 2] = 2'd0;  req_data_a[0 +: 8]  = 8'hC0;
    req_a = 4'b0101;
    step();
    check("postrst_gnt", 64'(gnt_a), 64'(4'b0001));
    check("postrst_busy", 64'(busy_a), 64'(0));
    step();
    req_a = '0;
    check("postrst_setup_lat_d", 64'(lat_d_a), 64'(8'hC0));
    step(); step(); step();
    check("postrst_idle", 64'({gnt_a, lat_en_a, busy_a, addr_err_a}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_latch_wr_sequencer

// File: doc/latch_wr_sequencer.md
Name: latch_wr_sequencer

Overview:
- Shared write controller for a bank of DEPTH level-sensitive D latches. Each latch is WIDTH bits, with a common D bus and a per-entry enable.
- Arbitrates write requests from NREQ requesters round-robin.
- Sequences each write as setup, enable, hold so D is stable around every En pulse. Latch transparency never overlaps a data change.
- Sits between requester logic and the latch array; the latch array itself is not part of this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, latch data width.
- DEPTH, 4, number of latch entries (1..16).
- AW, 2, address width; must satisfy 2**AW >= DEPTH.
- EN_CYCLES, 1, clock cycles En is held high per write (1..15).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  write request per requester; level, held until granted.
- req_addr  input  NREQ*AW  packed target entry per requester; slice i belongs to requester i.
- req_data  input  NREQ*WIDTH  packed write data per requester.
- gnt  output  NREQ  one-hot, one-cycle grant pulse; addr/data are captured on this cycle.
- lat_d  output  WIDTH  shared D bus to all latches.
- lat_en  output  DEPTH  one-hot per-entry latch enable.
- busy  output  1  high whenever the FSM is not IDLE.
- addr_err  output  1  one-cycle pulse when a granted addr >= DEPTH.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: gnt=0, lat_d=0, lat_en=0, busy=0, addr_err=0, FSM=IDLE, rr pointer=0, enable counter=0.
- Reset asserted mid-transaction forces lat_en low immediately, without waiting for a clock edge. The partially written latch keeps whatever it captured; no retry is performed.
- All outputs are registered. Nothing combinational runs from req to gnt.
- FSM states: IDLE, SETUP, ENABLE, HOLD.
- IDLE, any req high:
  - the arbiter picks a winner and asserts gnt[w] for one cycle;
  - addr and data are captured into internal registers;
  - next state is SETUP.
- IDLE, no req: stay in IDLE, all outputs at idle values.
- SETUP (1 cycle):
  - lat_d = captured data, lat_en = 0, busy = 1;
  - next state is ENABLE.
- ENABLE (EN_CYCLES cycles):
  - lat_en[addr] = 1 and lat_d stays stable;
  - the counter counts down, then the FSM moves to HOLD;
  - if addr >= DEPTH: lat_en stays 0, and addr_err pulses on the first ENABLE cycle only.
- HOLD (1 cycle):
  - lat_en = 0, lat_d still held;
  - next state is IDLE.
- lat_d changes only on the IDLE->SETUP-sequence capture. It is never updated while any lat_en bit is high, or in the cycle after.
- Latency: gnt-to-lat_en rising is 2 cycles (gnt cycle, then SETUP). A transaction occupies 3+EN_CYCLES cycles including the gnt cycle.
- Back-to-back requests: the next grant is issued in the IDLE cycle after HOLD. Sustained throughput is one write per 3+EN_CYCLES cycles.
- Round-robin arbitration:
  - priority search starts at (last_winner+1) mod NREQ;
  - the pointer updates only on a grant;
  - after reset, requester 0 has top priority;
  - no requester waits more than NREQ-1 grants.
- Requests are sampled only in IDLE. A req raised and dropped while busy is never seen.
- The requester drops req in the cycle after gnt; a req still high is treated as a new request.
- Simultaneous req from all requesters: granted in pointer order, one per transaction.
- lat_en is never multi-hot and is never high in IDLE, SETUP or HOLD.

Decomposition:
- Package latch_ctrl_pkg holds the state enum (IDLE, SETUP, ENABLE, HOLD) and the counter width constant (4 bits for EN_CYCLES).
- Sub-module rr_arbiter (params NREQ):
  - inputs: req, advance;
  - outputs: one-hot grant, winner index;
  - contains the rotating pointer register.
- The FSM, capture registers and enable decode stay in latch_wr_sequencer.

Test Plan:
1. Reset/idle: rst_n=0 for 3 cycles, then 1, req=0 -> all outputs 0 and busy=0 for 10 cycles.
2. Single write, EN_CYCLES=1: req[2]=1, addr=3, data=0xA5.
   - gnt=0100 at cycle t; SETUP at t+1 with lat_d=0xA5 and lat_en=0;
   - lat_en=1000 at t+2 only; HOLD at t+3 with lat_d still 0xA5; busy back to 0 at t+4.
3. All four requesting simultaneously, distinct data 0x11/0x22/0x33/0x44:
   - grants go in order 0,1,2,3, each 4 cycles apart;
   - the latch model ends holding the matching data per addr.
4. Fairness: requester 0 requests continuously while requester 3 requests once -> requester 3 is granted within 3 transactions, and requester 0 is then granted next.
5. EN_CYCLES=3 plus out-of-range address (DEPTH=3, addr=3):
   - lat_en stays 000 for all 3 ENABLE cycles;
   - addr_err pulses once; busy lasts 5 cycles.
6. Reset mid-ENABLE:
   - drop rst_n while lat_en=0010 -> lat_en=0 with no clock edge needed;
   - after release, FSM is IDLE and the next grant goes to requester 0.
